// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the program/sprite RAM arbiter.
package chip8_mem_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LD,
        REQ_CPU,
        REQ_BLT
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port: req/ack handshake, access fields and optional lock.
interface ram_arbiter_if #(
    parameter int AW = chip8_mem_pkg::ADDR_WIDTH,
    parameter int DW = chip8_mem_pkg::DATA_WIDTH
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, wr, addr, wdata, lock,
        input  ack, rdata
    );

    modport slave (
        input  req, wr, addr, wdata, lock,
        output ack, rdata
    );
endinterface

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select: lock owner first, then ld, then
// round-robin between cpu and blt. Ports acked this cycle are ignored.
module mem_arb_pick
    import chip8_mem_pkg::*;
(
    input  logic       ld_req,
    input  logic       cpu_req,
    input  logic       blt_req,
    input  logic       cpu_lock,
    input  logic       blt_lock,
    input  req_id_t    lock_owner,
    input  req_id_t    last_served,
    input  logic [2:0] acked,
    output req_id_t    winner,
    output logic       locked
);
    logic ld_ok;
    logic cpu_ok;
    logic blt_ok;

    always_comb begin
        ld_ok  = ld_req  & ~acked[0];
        cpu_ok = cpu_req & ~acked[1];
        blt_ok = blt_req & ~acked[2];
        locked = ((lock_owner == REQ_CPU) && cpu_lock)
              || ((lock_owner == REQ_BLT) && blt_lock);
        winner = REQ_NONE;
        if (locked) begin
            if (lock_owner == REQ_CPU && cpu_ok)
                winner = REQ_CPU;
            else if (lock_owner == REQ_BLT && blt_ok)
                winner = REQ_BLT;
        end else if (ld_ok) begin
            winner = REQ_LD;
        end else if (cpu_ok && blt_ok) begin
            // the pair member not served last goes next
            if (last_served == REQ_CPU)
                winner = REQ_BLT;
            else
                winner = REQ_CPU;
        end else if (cpu_ok) begin
            winner = REQ_CPU;
        end else if (blt_ok) begin
            winner = REQ_BLT;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Serialises ld/cpu/blt accesses onto a single-port synchronous RAM,
// one access per IDLE -> ACCESS -> RESP round.
module ram_arbiter #(
    parameter int ADDR_WIDTH = chip8_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = chip8_mem_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  res,
    ram_arbiter_if.slave          ld,
    ram_arbiter_if.slave          cpu,
    ram_arbiter_if.slave          blt,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_in,
    input  logic [DATA_WIDTH-1:0] ram_out,
    output logic                  busy
);
    import chip8_mem_pkg::*;

    state_t                state;
    req_id_t               owner;
    req_id_t               lock_owner;
    req_id_t               last_served;
    req_id_t               winner;
    logic                  locked;
    logic                  owner_lock;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    mem_arb_pick u_pick (
        .ld_req      (ld.req),
        .cpu_req     (cpu.req),
        .blt_req     (blt.req),
        .cpu_lock    (cpu.lock),
        .blt_lock    (blt.lock),
        .lock_owner  (lock_owner),
        .last_served (last_served),
        .acked       ({blt.ack, cpu.ack, ld.ack}),
        .winner      (winner),
        .locked      (locked)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        unique case (winner)
            REQ_LD: begin
                sel_wr    = ld.wr;
                sel_addr  = ld.addr;
                sel_wdata = ld.wdata;
            end
            REQ_CPU: begin
                sel_wr    = cpu.wr;
                sel_addr  = cpu.addr;
                sel_wdata = cpu.wdata;
            end
            REQ_BLT: begin
                sel_wr    = blt.wr;
                sel_addr  = blt.addr;
                sel_wdata = blt.wdata;
            end
            default: ;
        endcase
        owner_lock = ((owner == REQ_CPU) && cpu.lock)
                  || ((owner == REQ_BLT) && blt.lock);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            owner       <= REQ_NONE;
            lock_owner  <= REQ_NONE;
            last_served <= REQ_BLT;
            ram_en      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_addr    <= '0;
            ram_in      <= '0;
            busy        <= 1'b0;
            ld.ack      <= 1'b0;
            cpu.ack     <= 1'b0;
            blt.ack     <= 1'b0;
            ld.rdata    <= '0;
            cpu.rdata   <= '0;
            blt.rdata   <= '0;
        end else begin
            ld.ack  <= 1'b0;
            cpu.ack <= 1'b0;
            blt.ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!locked)
                        lock_owner <= REQ_NONE;
                    ram_en <= (winner != REQ_NONE);
                    ram_wr <= (winner != REQ_NONE) && sel_wr;
                    if (winner != REQ_NONE) begin
                        ram_addr <= sel_addr;
                        ram_in   <= sel_wdata;
                        owner    <= winner;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    unique case (owner)
                        REQ_LD: begin
                            ld.rdata <= ram_out;
                            ld.ack   <= 1'b1;
                        end
                        REQ_CPU: begin
                            cpu.rdata <= ram_out;
                            cpu.ack   <= 1'b1;
                        end
                        REQ_BLT: begin
                            blt.rdata <= ram_out;
                            blt.ack   <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (owner == REQ_CPU || owner == REQ_BLT)
                        last_served <= owner;
                    if (owner_lock)
                        lock_owner <= owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised and directed bench for ram_arbiter with a RAM model and
// a transaction-level scoreboard of expected memory contents.
module tb_ram_arbiter;
    import chip8_mem_pkg::*;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        lock;
    } op_t;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        ram_en, ram_wr, busy;
    logic [11:0] ram_addr;
    logic [7:0]  ram_in;
    logic [7:0]  ram_out = 8'h00;

    always #5 clk = ~clk;

    ram_arbiter_if ld_if ();
    ram_arbiter_if cpu_if ();
    ram_arbiter_if blt_if ();

    ram_arbiter dut (
        .clk      (clk),
        .res      (res),
        .ld       (ld_if),
        .cpu      (cpu_if),
        .blt      (blt_if),
        .ram_en   (ram_en),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_in   (ram_in),
        .ram_out  (ram_out),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(int i);
        return 8'(i * 7 + 3);
    endfunction

    // environment RAM: one cycle read latency, read-before-write
    logic [7:0]  ram [4096];
    logic        ram_ready = 1'b0;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end
        if (ram_en) begin
            if (ram_wr) ram[ram_addr] <= ram_in;
            ram_out <= ram[ram_addr];
        end
    end

    // requester model: presents queued ops, renews on ack, logs results
    logic [7:0]  model [4096];
    op_t         q [3][$];
    bit          active [3];
    int          start_c [3];
    logic        req_d [3], wr_d [3], lock_d [3];
    logic [11:0] addr_d [3];
    logic [7:0]  wdata_d [3];
    int          log_port [$];
    int          log_lat [$];
    logic [7:0]  got_q [3][$];
    logic [7:0]  exp_q [3][$];
    int          overlap = 0;
    int          spurious = 0;
    logic        prev_en = 1'b0;

    assign ld_if.req    = req_d[0];
    assign ld_if.wr     = wr_d[0];
    assign ld_if.addr   = addr_d[0];
    assign ld_if.wdata  = wdata_d[0];
    assign ld_if.lock   = 1'b0;
    assign cpu_if.req   = req_d[1];
    assign cpu_if.wr    = wr_d[1];
    assign cpu_if.addr  = addr_d[1];
    assign cpu_if.wdata = wdata_d[1];
    assign cpu_if.lock  = lock_d[1];
    assign blt_if.req   = req_d[2];
    assign blt_if.wr    = wr_d[2];
    assign blt_if.addr  = addr_d[2];
    assign blt_if.wdata = wdata_d[2];
    assign blt_if.lock  = lock_d[2];

    always @(negedge clk) begin
        logic       a [3];
        logic [7:0] rd [3];
        op_t        op;
        a[0] = ld_if.ack;  rd[0] = ld_if.rdata;
        a[1] = cpu_if.ack; rd[1] = cpu_if.rdata;
        a[2] = blt_if.ack; rd[2] = blt_if.rdata;
        if (res) begin
            for (int p = 0; p < 3; p++) begin
                q[p].delete();
                active[p] = 1'b0;
            end
            prev_en = 1'b0;
        end else begin
            if (ram_en && prev_en) overlap++;
            if (int'(a[0]) + int'(a[1]) + int'(a[2]) > 1) overlap++;
            prev_en = ram_en;
            for (int p = 0; p < 3; p++) begin
                if (a[p] && !active[p]) spurious++;
                if (a[p] && active[p]) begin
                    op = q[p][0];
                    log_port.push_back(p);
                    log_lat.push_back(cyc - start_c[p]);
                    if (op.wr) model[op.addr] = op.wdata;
                    else begin
                        got_q[p].push_back(rd[p]);
                        exp_q[p].push_back(model[op.addr]);
                    end
                    void'(q[p].pop_front());
                    active[p] = 1'b0;
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (!active[p] && q[p].size() != 0) begin
                    active[p]  = 1'b1;
                    start_c[p] = cyc;
                end
            end
        end
        for (int p = 0; p < 3; p++) begin
            req_d[p] = active[p];
            if (active[p]) begin
                wr_d[p]    = q[p][0].wr;
                addr_d[p]  = q[p][0].addr;
                wdata_d[p] = q[p][0].wdata;
                lock_d[p]  = q[p][0].lock;
            end else begin
                wr_d[p]    = 1'b0;
                addr_d[p]  = '0;
                wdata_d[p] = '0;
                lock_d[p]  = 1'b0;
            end
        end
    end

    task automatic push(input int p, input logic wr, input logic [11:0] a,
                        input logic [7:0] d, input logic lk);
        op_t op;
        op.wr = wr; op.addr = a; op.wdata = d; op.lock = lk;
        q[p].push_back(op);
    endtask

    task automatic clear_logs();
        log_port.delete();
        log_lat.delete();
        for (int p = 0; p < 3; p++) begin
            got_q[p].delete();
            exp_q[p].delete();
        end
        overlap  = 0;
        spurious = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0
                && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        model[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); res = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;
    endtask

    task automatic check_reads(input string name);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < got_q[p].size(); i++) begin
                n_checks++;
                if (got_q[p][i] !== exp_q[p][i]) begin
                    n_fail++;
                    $display("FAIL %s rdata port%0d #%0d: got %h want %h",
                             name, p, i, got_q[p][i], exp_q[p][i]);
                end
            end
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ram_en, ram_wr, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000", {ram_en, ram_wr, busy});
        end
        n_checks++;
        if ({ram_addr, ram_in} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h want 0", {ram_addr, ram_in});
        end
        n_checks++;
        if ({ld_if.ack, cpu_if.ack, blt_if.ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ack: got %b want 000",
                     {ld_if.ack, cpu_if.ack, blt_if.ack});
        end
        n_checks++;
        if ({ld_if.rdata, cpu_if.rdata, blt_if.rdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0",
                     {ld_if.rdata, cpu_if.rdata, blt_if.rdata});
        end
        res = 1'b0;
    endtask

    task automatic test_single_read();
        bit ok;
        preload(12'h180, 8'hA2);
        clear_logs();
        @(posedge clk); #1;
        push(1, 1'b0, 12'h180, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({ram_en, ram_wr, ram_addr} !== {1'b1, 1'b0, 12'h180}) begin
            n_fail++;
            $display("FAIL single_cmd: got en=%b wr=%b addr=%h want 1 0 180",
                     ram_en, ram_wr, ram_addr);
        end
        wait_done(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout: got 0 want 1"); end
        n_checks++;
        if (log_lat.size() != 1 || log_lat[0] != 3) begin
            n_fail++;
            $display("FAIL single_latency: got n=%0d lat=%0d want 1 3",
                     log_lat.size(), log_lat.size() ? log_lat[0] : -1);
        end
        n_checks++;
        if (got_q[1].size() != 1 || got_q[1][0] !== 8'hA2) begin
            n_fail++;
            $display("FAIL single_rdata: got %h want a2", cpu_if.rdata);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (log_port.size() != 1 || spurious != 0) begin
            n_fail++;
            $display("FAIL single_pulse: got acks=%0d spurious=%0d want 1 0",
                     log_port.size(), spurious);
        end
    endtask

    task automatic test_pair();
        bit ok;
        do_reset();
        preload(12'h010, 8'h5C);
        preload(12'h020, 8'h3D);
        clear_logs();
        @(posedge clk); #1;
        push(1, 1'b0, 12'h010, 8'h00, 1'b0);
        push(2, 1'b0, 12'h020, 8'h00, 1'b0);
        wait_done(30, ok);
        n_checks++;
        if (!ok || log_port.size() != 2) begin
            n_fail++;
            $display("FAIL pair_count: got %0d acks want 2", log_port.size());
        end else begin
            n_checks++;
            if (log_port[0] != 1 || log_lat[0] != 3
                || log_port[1] != 2 || log_lat[1] != 6) begin
                n_fail++;
                $display("FAIL pair_order: got p%0d@%0d p%0d@%0d want p1@3 p2@6",
                         log_port[0], log_lat[0], log_port[1], log_lat[1]);
            end
        end
        n_checks++;
        if (blt_if.rdata !== 8'h3D) begin
            n_fail++;
            $display("FAIL pair_blt_rdata: got %h want 3d", blt_if.rdata);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL pair_overlap: got %0d want 0", overlap);
        end
        check_reads("pair");
    endtask

    task automatic test_ld_priority();
        bit ok;
        clear_logs();
        @(posedge clk); #1;
        push(0, 1'b1, 12'h200, 8'h12, 1'b0);
        push(1, 1'b0, 12'h200, 8'h00, 1'b0);
        wait_done(30, ok);
        n_checks++;
        if (!ok || log_port.size() != 2) begin
            n_fail++;
            $display("FAIL ldprio_count: got %0d acks want 2", log_port.size());
        end else begin
            n_checks++;
            if (log_port[0] != 0 || log_lat[0] != 3
                || log_port[1] != 1 || log_lat[1] != 6) begin
                n_fail++;
                $display("FAIL ldprio_order: got p%0d@%0d p%0d@%0d want p0@3 p1@6",
                         log_port[0], log_lat[0], log_port[1], log_lat[1]);
            end
        end
        n_checks++;
        if (cpu_if.rdata !== 8'h12) begin
            n_fail++;
            $display("FAIL ldprio_rdata: got %h want 12", cpu_if.rdata);
        end
    endtask

    task automatic test_lock();
        bit ok;
        int want_lat [4] = '{3, 4, 4, 14};
        int want_port [4] = '{1, 1, 1, 2};
        do_reset();
        preload(12'h050, 8'h77);
        clear_logs();
        @(posedge clk); #1;
        push(1, 1'b1, 12'h300, 8'h01, 1'b1);
        push(1, 1'b1, 12'h301, 8'h02, 1'b1);
        push(1, 1'b1, 12'h302, 8'h03, 1'b1);
        push(2, 1'b0, 12'h050, 8'h00, 1'b0);
        wait_done(60, ok);
        n_checks++;
        if (!ok || log_port.size() != 4) begin
            n_fail++;
            $display("FAIL lock_count: got %0d acks want 4", log_port.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_port[i] != want_port[i] || log_lat[i] != want_lat[i]) begin
                    n_fail++;
                    $display("FAIL lock_seq #%0d: got p%0d@%0d want p%0d@%0d",
                             i, log_port[i], log_lat[i], want_port[i], want_lat[i]);
                end
            end
        end
        n_checks++;
        if ({ram[12'h300], ram[12'h301], ram[12'h302]} !== 24'h010203) begin
            n_fail++;
            $display("FAIL lock_ram: got %h%h%h want 010203",
                     ram[12'h300], ram[12'h301], ram[12'h302]);
        end
        n_checks++;
        if (blt_if.rdata !== 8'h77) begin
            n_fail++;
            $display("FAIL lock_blt_rdata: got %h want 77", blt_if.rdata);
        end
    endtask

    task automatic test_reset_access();
        bit ok;
        clear_logs();
        @(posedge clk); #1;
        push(1, 1'b1, 12'h400, 8'h55, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ram_en, ram_wr, busy, ram_addr, ram_in} !== 23'h0) begin
            n_fail++;
            $display("FAIL rstacc_outputs: got en=%b wr=%b busy=%b addr=%h in=%h want 0",
                     ram_en, ram_wr, busy, ram_addr, ram_in);
        end
        n_checks++;
        if ({cpu_if.ack, cpu_if.rdata} !== 9'h0) begin
            n_fail++;
            $display("FAIL rstacc_cpu: got ack=%b rdata=%h want 0 00",
                     cpu_if.ack, cpu_if.rdata);
        end
        n_checks++;
        if (ram[12'h400] !== 8'h55) begin
            n_fail++;
            $display("FAIL rstacc_commit: got %h want 55", ram[12'h400]);
        end
        res = 1'b0;
        model[12'h400] = 8'h55;
        repeat (6) @(negedge clk);
        n_checks++;
        if (log_port.size() != 0 || spurious != 0) begin
            n_fail++;
            $display("FAIL rstacc_noack: got %0d acks %0d spurious want 0",
                     log_port.size(), spurious);
        end
        @(posedge clk); #1;
        push(1, 1'b0, 12'h400, 8'h00, 1'b0);
        wait_done(20, ok);
        n_checks++;
        if (!ok || log_lat.size() != 1 || log_lat[0] != 3
            || cpu_if.rdata !== 8'h55) begin
            n_fail++;
            $display("FAIL rstacc_after: got n=%0d rdata=%h want 1 55",
                     log_lat.size(), cpu_if.rdata);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int n_cpu;
        do_reset();
        clear_logs();
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            push(1, 1'b0, 12'($urandom_range(0, 4095)), 8'h00, 1'b0);
            push(2, 1'b0, 12'($urandom_range(0, 4095)), 8'h00, 1'b0);
        end
        wait_done(100, ok);
        n_checks++;
        if (!ok || log_port.size() != 12) begin
            n_fail++;
            $display("FAIL rr_count: got %0d acks want 12", log_port.size());
        end else begin
            n_cpu = 0;
            for (int i = 0; i < 12; i++) begin
                if (log_port[i] == 1) n_cpu++;
                n_checks++;
                if (log_port[i] != ((i % 2 == 0) ? 1 : 2)
                    || log_lat[i] != ((i == 0) ? 3 : 6)) begin
                    n_fail++;
                    $display("FAIL rr_seq #%0d: got p%0d@%0d want p%0d@%0d", i,
                             log_port[i], log_lat[i], (i % 2 == 0) ? 1 : 2,
                             (i == 0) ? 3 : 6);
                end
            end
            n_checks++;
            if (n_cpu != 6) begin
                n_fail++;
                $display("FAIL rr_share: got cpu=%0d want 6", n_cpu);
            end
        end
        check_reads("rr");
    endtask

    task automatic test_random();
        bit ok;
        int p, mx;
        clear_logs();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            p = int'($urandom_range(0, 2));
            push(p, 1'($urandom_range(0, 1)), 12'(12'h600 + $urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(posedge clk);
        end
        wait_done(2000, ok);
        n_checks++;
        if (!ok || log_port.size() != 40 || spurious != 0 || overlap != 0) begin
            n_fail++;
            $display("FAIL rand_mix: got acks=%0d spurious=%0d overlap=%0d want 40 0 0",
                     log_port.size(), spurious, overlap);
        end
        check_reads("rand");
        clear_logs();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            p = int'($urandom_range(1, 2));
            push(p, 1'($urandom_range(0, 1)), 12'(12'h600 + $urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        wait_done(2000, ok);
        mx = 0;
        foreach (log_lat[i]) if (log_lat[i] > mx) mx = log_lat[i];
        n_checks++;
        if (!ok || log_port.size() != 30 || mx > 6) begin
            n_fail++;
            $display("FAIL rand_pair_wait: got acks=%0d maxlat=%0d want 30 <=6",
                     log_port.size(), mx);
        end
        check_reads("randpair");
        for (int a = 12'h600; a < 12'h610; a++) begin
            n_checks++;
            if (ram[a] !== model[a]) begin
                n_fail++;
                $display("FAIL rand_ram %h: got %h want %h", a[11:0], ram[a], model[a]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = init_val(i);
        test_reset();
        test_single_read();
        test_pair();
        test_ld_priority();
        test_lock();
        test_reset_access();
        test_round_robin();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
